rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that grants one shared resource to one of N requesters.
- It is the responder side of the OR-combined request bus: the requesters' lines are OR-ed to detect demand, and this block answers with a registered one-hot grant.
- The grant is held until the owner releases it, or until an optional hold-time limit forces a handover.
- It sits between requester blocks and a single shared bus or resource.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 0, maximum consecutive grant cycles before forced revoke; 0 disables the limit.
- IDW, $clog2(N), width of grant_id; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  N  per-requester request; a requester holds it high for as long as it wants ownership.
- grant  output  N  registered one-hot grant; all zero when the resource is free.
- grant_valid  output  1  OR of grant.
- grant_id  output  IDW  index of the current owner; 0 when grant_valid=0.
- preempt  output  1  one-cycle pulse, asserted on the cycle a grant is forcibly revoked.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - grant=0, grant_valid=0, grant_id=0, preempt=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Reset mid-grant drops the grant on that same edge. No pulse is produced.
- State IDLE:
  - If |req=0, stay in IDLE.
  - Otherwise choose the winner: the first index i with req[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap modulo N).
  - On the next edge: grant[i]=1, grant_id=i, counter=1, state=OWNED. Request-to-grant latency is exactly 1 cycle.
- State OWNED (owner o):
  - Normal release: if req[o]=0 at an edge, then on that edge grant=0, ptr=(o+1) mod N, state=IDLE.
  - Forced revoke: if MAX_HOLD>0, req[o]=1 and counter==MAX_HOLD at an edge, then on that edge grant=0, preempt=1 for exactly one cycle, ptr=(o+1) mod N, state=IDLE.
  - Otherwise: grant holds and counter increments (saturating at MAX_HOLD).
  - Requests from other indices are ignored while OWNED. Changes on req[j], j≠o, have no effect.
- Handover gap: at least one cycle with grant_valid=0 always separates two grants, including back-to-back requests by the same requester.
- Fairness: after any release or revoke the previous owner has the lowest priority.
- Preempted sole requester: if the preempted owner is still the only requester, it is re-granted 1 cycle after IDLE.
- Simultaneous requests: resolved purely by the rotating scan; no fixed priority.
- Width rules:
  - ptr and grant_id are IDW bits. Wrap is explicit (o==N-1 -> 0), so non-power-of-two N is correct.
  - The counter is wide enough for MAX_HOLD. It is not instantiated when MAX_HOLD=0.
- Invariants (assertable):
  - $countones(grant)<=1.
  - grant_valid implies req[grant_id] was 1 at the previous edge.
  - preempt implies grant_valid=0 on the same cycle.

Decomposition:
- Package arb_pkg holds:
  - the state typedef enum {IDLE, OWNED};
  - the default N and MAX_HOLD constants;
  - a function for the wrap increment of ptr.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: any, idx[IDW].
  - It is instantiated once and is reusable by other arbiters in the design.
- State register, counter and output registers live in rr_arbiter.

Test Plan:
- Reset mid-grant: N=4, req=0001 until grant=0001, then rst_n=0 for one edge -> grant=0000, grant_id=0 on that edge; after release, req=0001 -> grant=0001 one cycle later (ptr back to 0).
- Single request: from reset, req=0100 at cycle 0 -> grant=0100, grant_id=2 at cycle 1; drop req at cycle 5 -> grant=0000 at cycle 5's edge.
- Rotation: req=1111 held, each owner drops its req for one cycle after 2 cycles of grant, then re-raises it -> grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- Wrap and skip: ptr=3 (after owner 2 releases), req=0011 -> grant_id=0, then after release grant_id=1; req=1000 with ptr=0 -> grant_id=3.
- Preemption: MAX_HOLD=3, req=0011 held continuously -> grant_id=0 for 3 cycles, then preempt=1 and grant=0000 for 1 cycle, then grant_id=1 for 3 cycles, then 0 again.
- Preempted sole requester: MAX_HOLD=2, req=0010 only -> grant 2 cycles, preempt pulse, 1 idle cycle, re-grant to 1; the $countones(grant)<=1 assertion holds throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_pkg;

    // Arbiter ownership state.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Default number of requesters.
    localparam int ARB_N_DEF        = 4;
    // Default hold limit; 0 means no limit.
    localparam int ARB_MAX_HOLD_DEF = 0;

    // Advance a pointer by one with an explicit wrap, so that N does not
    // need to be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

    // Position 'off' steps after 'base' in a ring of n entries.
    // Both inputs are expected to be below n.
    function automatic int unsigned rot_index(input int unsigned base, input int unsigned off,
                                              input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = ARB_N_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] cand;

    // Scan from the farthest offset back to ptr so the closest asserted
    // request after ptr is the last (winning) assignment.
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDW'(rot_index(32'(ptr), unsigned'(k), N));
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until release or hold-limit revoke.
// Latency: request to grant 1 cycle; release/revoke drops grant on the same edge.
// Backpressure: other requesters wait while owned; one idle cycle always separates two grants.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           preempt
);

    arb_state_e     state;
    logic [IDW-1:0] ptr;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           owner_req;
    logic           hold_expired;
    logic [N-1:0]   pick_onehot;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // grant_id is kept at 0 while free, so this read is only meaningful in OWNED.
    assign owner_req   = req[grant_id];
    assign grant_valid = |grant;
    assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;

    // Hold counter exists only when a limit is configured.
    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int CW = $clog2(MAX_HOLD + 1);
            logic [CW-1:0] hold_cnt;

            // Count owned cycles starting at 1 on the granting edge, saturating at the limit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                end else if (state == IDLE) begin
                    hold_cnt <= pick_any ? CW'(1) : '0;
                end else if (hold_cnt != CW'(MAX_HOLD)) begin
                    hold_cnt <= hold_cnt + CW'(1);
                end
            end

            assign hold_expired = (hold_cnt == CW'(MAX_HOLD));
        end else begin : g_no_hold
            assign hold_expired = 1'b0;
        end
    endgenerate

    // Ownership FSM with grant, owner id, rotation pointer and preempt pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant    <= pick_onehot;
                        grant_id <= pick_idx;
                        state    <= OWNED;
                    end
                end
                OWNED: begin
                    // Owner let go, or held too long: free the resource and make
                    // the old owner the lowest priority. A revoke is reported only
                    // when the owner still wanted the resource.
                    if (!owner_req || hold_expired) begin
                        grant    <= '0;
                        grant_id <= '0;
                        ptr      <= IDW'(wrap_inc(32'(grant_id), N));
                        preempt  <= owner_req;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // At most one owner at a time.
    a_onehot: assert property (@(posedge clk) $onehot0(grant));
    // A revoke cycle never shows a grant.
    a_preempt_free: assert property (@(posedge clk) preempt |-> !grant_valid);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: three instances (no limit, limit 3, limit 2).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_rr_arbiter;

    logic       clk;
    logic       rst_a       [3];
    logic [3:0] req_a       [3];
    logic [3:0] grant_a     [3];
    logic       gv_a        [3];
    logic [1:0] id_a        [3];
    logic       pre_a       [3];
    logic [3:0] prev_req    [3];

    int total;
    int bad;

    typedef struct {
        int         sel;
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter #(.N(4), .MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst_n(rst_a[0]), .req(req_a[0]), .grant(grant_a[0]),
        .grant_valid(gv_a[0]), .grant_id(id_a[0]), .preempt(pre_a[0])
    );
    rr_arbiter #(.N(4), .MAX_HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_a[1]), .req(req_a[1]), .grant(grant_a[1]),
        .grant_valid(gv_a[1]), .grant_id(id_a[1]), .preempt(pre_a[1])
    );
    rr_arbiter #(.N(4), .MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_a[2]), .req(req_a[2]), .grant(grant_a[2]),
        .grant_valid(gv_a[2]), .grant_id(id_a[2]), .preempt(pre_a[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int s, input logic r, input logic [3:0] q,
                                input logic [3:0] g, input logic [1:0] i, input logic p);
        tbl.push_back('{sel: s, rst_n: r, req: q, grant: g, id: i, pre: p});
    endfunction

    // Apply inputs to one instance, clock once, compare all outputs.
    task automatic step_check(input string tag, input int s, input logic r, input logic [3:0] q,
                              input logic [3:0] g, input logic [1:0] i, input logic p);
        rst_a[s] = r;
        req_a[s] = q;
        @(posedge clk);
        #1;
        check({tag, " grant"}, 32'(grant_a[s]), 32'(g));
        check({tag, " id"},    32'(id_a[s]),    32'(i));
        check({tag, " pre"},   32'(pre_a[s]),   32'(p));
        check({tag, " gv"},    32'(gv_a[s]),    32'(|g));
    endtask

    // Invariant monitor: remember the requests each edge saw.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) prev_req[i] <= req_a[i];
    end

    // Invariant monitor: one owner at most, owner was requesting, no grant during a revoke pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_a[i] === 1'b1) begin
                check($sformatf("inv%0d onehot", i), 32'($countones(grant_a[i]) <= 1), 32'd1);
                if (gv_a[i] === 1'b1)
                    check($sformatf("inv%0d owner_req", i), 32'(prev_req[i][id_a[i]]), 32'd1);
                if (pre_a[i] === 1'b1)
                    check($sformatf("inv%0d pre_free", i), 32'(gv_a[i]), 32'd0);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) begin
            rst_a[i]    = 1'b0;
            req_a[i]    = 4'b0000;
            prev_req[i] = 4'b0000;
        end

        // ---------------- instance without hold limit ----------------
        add(0, 0, 4'b0000, 4'b0000, 2'd0, 0);   // reset state
        add(0, 1, 4'b0100, 4'b0100, 2'd2, 0);   // single request, 1-cycle latency
        add(0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        add(0, 1, 4'b1101, 4'b0100, 2'd2, 0);   // others ignored while owned
        add(0, 1, 4'b0110, 4'b0100, 2'd2, 0);
        add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);   // release on the edge, ptr=3
        add(0, 1, 4'b0011, 4'b0001, 2'd0, 0);   // wrap: scan 3,0 -> 0
        add(0, 1, 4'b0010, 4'b0000, 2'd0, 0);   // owner 0 releases, ptr=1
        add(0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);   // ptr=2
        add(0, 1, 4'b1000, 4'b1000, 2'd3, 0);   // skip 2 -> 3
        add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);   // ptr=0
        add(0, 1, 4'b1000, 4'b1000, 2'd3, 0);   // ptr=0, only req 3
        add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);   // ptr=0
        add(0, 1, 4'b1111, 4'b0001, 2'd0, 0);   // rotation 0
        add(0, 1, 4'b1111, 4'b0001, 2'd0, 0);
        add(0, 1, 4'b1110, 4'b0000, 2'd0, 0);
        add(0, 1, 4'b1111, 4'b0010, 2'd1, 0);   // rotation 1
        add(0, 1, 4'b1111, 4'b0010, 2'd1, 0);
        add(0, 1, 4'b1101, 4'b0000, 2'd0, 0);
        add(0, 1, 4'b1111, 4'b0100, 2'd2, 0);   // rotation 2
        add(0, 1, 4'b1111, 4'b0100, 2'd2, 0);
        add(0, 1, 4'b1011, 4'b0000, 2'd0, 0);
        add(0, 1, 4'b1111, 4'b1000, 2'd3, 0);   // rotation 3
        add(0, 1, 4'b1111, 4'b1000, 2'd3, 0);
        add(0, 1, 4'b0111, 4'b0000, 2'd0, 0);
        add(0, 1, 4'b1111, 4'b0001, 2'd0, 0);   // rotation back to 0
        add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);   // ptr=1
        add(0, 1, 4'b0001, 4'b0001, 2'd0, 0);   // grant 0 with ptr=1
        add(0, 0, 4'b0001, 4'b0000, 2'd0, 0);   // reset mid-grant drops grant, ptr=0
        add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 1, 4'b0011, 4'b0001, 2'd0, 0);   // ptr back at 0 -> 0 beats 1
        add(0, 1, 4'b0000, 4'b0000, 2'd0, 0);

        // ---------------- instance with MAX_HOLD=3 ----------------
        add(1, 0, 4'b0000, 4'b0000, 2'd0, 0);
        add(1, 1, 4'b0011, 4'b0001, 2'd0, 0);
        add(1, 1, 4'b0011, 4'b0001, 2'd0, 0);
        add(1, 1, 4'b0011, 4'b0001, 2'd0, 0);
        add(1, 1, 4'b0011, 4'b0000, 2'd0, 1);   // forced revoke
        add(1, 1, 4'b0011, 4'b0010, 2'd1, 0);
        add(1, 1, 4'b0011, 4'b0010, 2'd1, 0);
        add(1, 1, 4'b0011, 4'b0010, 2'd1, 0);
        add(1, 1, 4'b0011, 4'b0000, 2'd0, 1);
        add(1, 1, 4'b0011, 4'b0001, 2'd0, 0);
        add(1, 1, 4'b0000, 4'b0000, 2'd0, 0);   // plain release: no pulse

        for (int i = 0; i < tbl.size(); i++) begin
            step_check($sformatf("v%0d", i), tbl[i].sel, tbl[i].rst_n, tbl[i].req,
                       tbl[i].grant, tbl[i].id, tbl[i].pre);
        end

        // ---------------- MAX_HOLD=2, preempted sole requester ----------------
        step_check("s2 rst",   2, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step_check("s2 g1",    2, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step_check("s2 g2",    2, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step_check("s2 rev",   2, 1'b1, 4'b0010, 4'b0000, 2'd0, 1'b1);
        step_check("s2 regr",  2, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step_check("s2 hold",  2, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step_check("s2 rev2",  2, 1'b1, 4'b0010, 4'b0000, 2'd0, 1'b1);
        step_check("s2 drop",  2, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step_check("s2 g3",    2, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step_check("s2 rel",   2, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step_check("s2 idle",  2, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
